// File: rtl/sp_pkg.sv
// Shared symbols for the serial link: idle/alignment comma and receiver states.
package sp_pkg;
    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        ACTIVE
    } state_t;
endpackage

// File: rtl/sp_comma_shift.sv
// MSB-first 8-bit deserialising shift register with a COMMA comparator.
module sp_comma_shift
    import sp_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] sr,
    output logic       is_comma
);

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[6:0], data_in};
        end
    end

    assign is_comma = (sr == COMMA);

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial link receiver: comma alignment, lock FSM and byte output registers.
// Define SP_RX_LOS_EN to drop out of ACTIVE after GAP_MAX comma-free byte slots.
module serial_parallel_rx
    import sp_pkg::*;
#(
    parameter int unsigned BC_LOCK = 4,
    parameter int unsigned GAP_MAX = 64
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

    logic [7:0] sr;
    logic       is_comma;
    logic       at_bnd;
    logic [2:0] bit_cnt;
    logic [3:0] comma_cnt;
    state_t     state;

`ifdef SP_RX_LOS_EN
    localparam int unsigned GW = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_N = GW'(GAP_MAX);
    logic [GW-1:0] gap_cnt;
`endif

    sp_comma_shift u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .sr       (sr),
        .is_comma (is_comma)
    );

    // The FSM looks at sr one edge after it fills, so bit_cnt==0 marks a whole byte in sr.
    assign at_bnd = (bit_cnt == 3'd0);

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state     <= SEARCH;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_stb  <= 1'b0;
            active    <= 1'b0;
`ifdef SP_RX_LOS_EN
            gap_cnt   <= '0;
`endif
        end else begin
            byte_stb <= 1'b0;
            bit_cnt  <= bit_cnt + 3'd1;
            unique case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt   <= 3'd1;
                        comma_cnt <= 4'd1;
`ifdef SP_RX_LOS_EN
                        gap_cnt   <= '0;
`endif
                        if (LOCK_N == 4'd1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    if (at_bnd) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if (comma_cnt + 4'd1 >= LOCK_N) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (at_bnd) begin
`ifdef SP_RX_LOS_EN
                        if (!is_comma && (gap_cnt + GW'(1) == GAP_N)) begin
                            state     <= SEARCH;
                            active    <= 1'b0;
                            valid_out <= 1'b0;
                            comma_cnt <= '0;
                            gap_cnt   <= '0;
                        end else begin
                            data_out  <= sr;
                            valid_out <= !is_comma;
                            byte_stb  <= 1'b1;
                            gap_cnt   <= is_comma ? '0 : gap_cnt + GW'(1);
                        end
`else
                        data_out  <= sr;
                        valid_out <= !is_comma;
                        byte_stb  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: reset, lock, payload, reject, reset mid-byte, LOS.
module tb_serial_parallel_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;

    int checks   = 0;
    int failures = 0;

    // Snapshot after the first bit of a byte, strobes seen on its other bits, active at its end
    logic       stb_f;
    logic [7:0] do_f;
    logic       vo_f;
    logic       act_f;
    logic       act_l;
    int         stb_o;

    always #5 clk_32f = ~clk_32f;

    serial_parallel_rx #(
        .BC_LOCK (4),
        .GAP_MAX (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_stb  (byte_stb),
        .active    (active)
    );

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        stb_o = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 7) begin
                stb_f = byte_stb;
                do_f  = data_out;
                vo_f  = valid_out;
                act_f = active;
            end else if (byte_stb) begin
                stb_o++;
            end
        end
        act_l = active;
    endtask

    task automatic pulse_reset();
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        checks++;
        if ({data_out, valid_out, byte_stb, active} !== 11'd0) begin
            failures++;
            $display("FAIL pulse_reset outputs got %h/%b/%b/%b want 00/0/0/0",
                     data_out, valid_out, byte_stb, active);
        end
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    // Four commas in SEARCH/LOCKING give no strobes; the fifth shows active; the sixth a BC strobe.
    task automatic idle_relock(input string tag);
        for (int k = 1; k <= 4; k++) begin
            send_byte(8'hBC);
            checks++;
            if ({stb_f, stb_o != 0, act_l} !== 3'b000) begin
                failures++;
                $display("FAIL %s comma%0d stb/extra/active got %b%b%b want 000",
                         tag, k, stb_f, stb_o != 0, act_l);
            end
        end
        send_byte(8'hBC);
        checks++;
        if ({stb_f, act_f} !== 2'b01) begin
            failures++;
            $display("FAIL %s lock stb/active got %b%b want 01", tag, stb_f, act_f);
        end
        send_byte(8'hBC);
        checks++;
        if ({stb_f, do_f, vo_f, act_f, stb_o != 0} !== {1'b1, 8'hBC, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s first_idle got stb=%b d=%h v=%b a=%b extra=%0d want 1 bc 0 1 0",
                     tag, stb_f, do_f, vo_f, act_f, stb_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f);
            data_in = 1'($urandom);
            @(posedge clk_32f);
            #1;
            checks++;
            if ({data_out, valid_out, byte_stb, active} !== 11'd0) begin
                failures++;
                $display("FAIL reset_cycle%0d got %h/%b/%b/%b want 00/0/0/0",
                         i, data_out, valid_out, byte_stb, active);
            end
        end
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic test_lock();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_relock("lock");
        send_byte(8'hBC);
        checks++;
        if ({stb_f, do_f, vo_f, act_f, stb_o != 0} !== {1'b1, 8'hBC, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lock_idle2 got stb=%b d=%h v=%b a=%b extra=%0d want 1 bc 0 1 0",
                     stb_f, do_f, vo_f, act_f, stb_o);
        end
    endtask

    task automatic test_payload();
        logic [7:0] seq [4];
        logic [7:0] prev [4];
        logic       pv [4];
        seq  = '{8'h5A, 8'hFF, 8'h00, 8'hBC};
        prev = '{8'hBC, 8'h5A, 8'hFF, 8'h00};
        pv   = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            send_byte(seq[k]);
            checks++;
            if ({stb_f, do_f, vo_f, act_f, stb_o != 0} !== {1'b1, prev[k], pv[k], 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL payload%0d got stb=%b d=%h v=%b a=%b extra=%0d want 1 %h %b 1 0",
                         k, stb_f, do_f, vo_f, act_f, stb_o, prev[k], pv[k]);
            end
        end
    endtask

    task automatic test_locking_reject();
        pulse_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h3C);
        checks++;
        if ({stb_f, stb_o != 0, act_l} !== 3'b000) begin
            failures++;
            $display("FAIL reject_3c stb/extra/active got %b%b%b want 000",
                     stb_f, stb_o != 0, act_l);
        end
        idle_relock("reject");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h5A);
        send_bit(1'b1);
        checks++;
        if ({byte_stb, data_out, valid_out, active} !== {1'b1, 8'h5A, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL mid_pre got stb=%b d=%h v=%b a=%b want 1 5a 1 1",
                     byte_stb, data_out, valid_out, active);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_reset();
        idle_relock("mid");
    endtask

    task automatic test_los();
        send_byte(8'h11);
        checks++;
        if ({stb_f, do_f, vo_f, act_f} !== {1'b1, 8'hBC, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL los_b1 got stb=%b d=%h v=%b a=%b want 1 bc 0 1",
                     stb_f, do_f, vo_f, act_f);
        end
        for (int k = 2; k <= 4; k++) begin
            send_byte(8'h11);
            checks++;
            if ({stb_f, do_f, vo_f, act_f} !== {1'b1, 8'h11, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL los_b%0d got stb=%b d=%h v=%b a=%b want 1 11 1 1",
                         k, stb_f, do_f, vo_f, act_f);
            end
        end
        send_byte(8'h11);
`ifdef SP_RX_LOS_EN
        checks++;
        if ({stb_f, do_f, vo_f, act_f} !== {1'b0, 8'h11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL los_drop got stb=%b d=%h v=%b a=%b want 0 11 0 0",
                     stb_f, do_f, vo_f, act_f);
        end
        send_byte(8'hBC);
        checks++;
        if ({stb_f, act_f, stb_o != 0} !== 3'b000) begin
            failures++;
            $display("FAIL los_after stb/active/extra got %b%b%b want 000",
                     stb_f, act_f, stb_o != 0);
        end
`else
        checks++;
        if ({stb_f, do_f, vo_f, act_f} !== {1'b1, 8'h11, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL los_hold got stb=%b d=%h v=%b a=%b want 1 11 1 1",
                     stb_f, do_f, vo_f, act_f);
        end
        send_byte(8'hBC);
        checks++;
        if ({stb_f, do_f, vo_f, act_f} !== {1'b1, 8'h11, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL los_hold5 got stb=%b d=%h v=%b a=%b want 1 11 1 1",
                     stb_f, do_f, vo_f, act_f);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_payload();
        test_locking_reject();
        test_reset_mid();
        test_los();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
